// File: rtl/display_pkg.sv
// Shared definitions for the BCD converter and the 8-digit display controller.
package display_pkg;

    localparam int unsigned NDIG        = 4;
    localparam int unsigned BCD_W       = 4 * NDIG;
    localparam int unsigned BIN_W_MAX   = 14;
    localparam int unsigned BIN_MAX_DEC = 9999;
    localparam logic [BCD_W-1:0] BCD_MAX = 16'h9999;

    typedef enum logic [1:0] {
        LOAD,
        SHIFT,
        STORE
    } fsm_state_t;

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every nibble >= 5, then shift in msb.
// Ports:
//   bcd      in   16  current packed BCD accumulator
//   msb      in   1   next binary bit shifted into the accumulator LSB
//   bcd_next out  16  accumulator after adjust-and-shift (combinational)
module bcd_dabble_step
    import display_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    input  logic             msb,
    output logic [BCD_W-1:0] bcd_next
);

    logic [BCD_W-1:0] adj;

    // Per-nibble correction so that a nibble >= 5 carries into the next digit after the shift.
    always_comb begin
        adj = bcd;
        for (int i = 0; i < int'(NDIG); i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    assign bcd_next = {adj[BCD_W-2:0], msb};

endmodule

// File: rtl/dual_bin2bcd_converter.sv
// Alternately converts two binary values to 4-digit packed BCD for the display.
// Ports:
//   clk       in   1      system clock
//   rst       in   1      synchronous active-high reset
//   bin_A     in   BIN_W  channel A binary value (display digits 3..0)
//   bin_B     in   BIN_W  channel B binary value (display digits 7..4)
//   hold      in   1      1 = do not publish at STORE; conversions keep running
//   digits_A  out  16     published BCD for A, [15:12] most significant digit
//   digits_B  out  16     published BCD for B
//   ovf_A     out  1      last published A exceeded 9999 (digits saturated)
//   ovf_B     out  1      last published B exceeded 9999
//   upd_A     out  1      one-cycle pulse when digits_A/ovf_A were written
//   upd_B     out  1      one-cycle pulse when digits_B/ovf_B were written
module dual_bin2bcd_converter
    import display_pkg::*;
#(
    parameter int unsigned BIN_W = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BIN_W-1:0] bin_A,
    input  logic [BIN_W-1:0] bin_B,
    input  logic             hold,
    output logic [BCD_W-1:0] digits_A,
    output logic [BCD_W-1:0] digits_B,
    output logic             ovf_A,
    output logic             ovf_B,
    output logic             upd_A,
    output logic             upd_B
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(BIN_W - 1);
    localparam logic [BIN_W_MAX-1:0] DEC_LIMIT = BIN_W_MAX'(BIN_MAX_DEC);

    fsm_state_t       state;
    logic             sel_b;
    logic [CNT_W-1:0] cnt;
    logic [BIN_W-1:0] bin_sr;
    logic [BCD_W-1:0] bcd;
    logic [BCD_W-1:0] bcd_next;
    logic             ovf_pend;

    logic [BIN_W-1:0]     bin_sel_c;
    logic [BIN_W_MAX-1:0] bin_ext_c;

    // Channel mux; the value is zero-extended before the overflow compare.
    assign bin_sel_c = sel_b ? bin_B : bin_A;
    assign bin_ext_c = BIN_W_MAX'(bin_sel_c);

    bcd_dabble_step u_step (
        .bcd      (bcd),
        .msb      (bin_sr[BIN_W-1]),
        .bcd_next (bcd_next)
    );

    // Sequencer: LOAD -> SHIFT x BIN_W -> STORE, alternating channels.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= LOAD;
            sel_b    <= 1'b0;
            cnt      <= '0;
            bin_sr   <= '0;
            bcd      <= '0;
            ovf_pend <= 1'b0;
            digits_A <= '0;
            digits_B <= '0;
            ovf_A    <= 1'b0;
            ovf_B    <= 1'b0;
            upd_A    <= 1'b0;
            upd_B    <= 1'b0;
        end else begin
            upd_A <= 1'b0;
            upd_B <= 1'b0;
            case (state)
                LOAD: begin
                    bin_sr   <= bin_sel_c;
                    bcd      <= '0;
                    cnt      <= '0;
                    ovf_pend <= (bin_ext_c > DEC_LIMIT);
                    state    <= SHIFT;
                end
                SHIFT: begin
                    bcd    <= bcd_next;
                    bin_sr <= bin_sr << 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == LAST_SHIFT) begin
                        state <= STORE;
                    end
                end
                STORE: begin
                    // Publish whole results only; saturate above 9999.
                    if (!hold) begin
                        if (sel_b) begin
                            digits_B <= ovf_pend ? BCD_MAX : bcd;
                            ovf_B    <= ovf_pend;
                            upd_B    <= 1'b1;
                        end else begin
                            digits_A <= ovf_pend ? BCD_MAX : bcd;
                            ovf_A    <= ovf_pend;
                            upd_A    <= 1'b1;
                        end
                    end
                    sel_b <= ~sel_b;
                    state <= LOAD;
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dual_bin2bcd_converter.sv
// Scoreboard bench for dual_bin2bcd_converter: the driver pushes expected
// publications per slot, the monitor pops and compares on every upd pulse.
module tb_dual_bin2bcd_converter;

    logic        clk;
    logic        rst;
    logic [13:0] bin_A;
    logic [13:0] bin_B;
    logic        hold;
    logic [15:0] digits_A;
    logic [15:0] digits_B;
    logic        ovf_A;
    logic        ovf_B;
    logic        upd_A;
    logic        upd_B;

    typedef struct {
        logic [15:0] d;
        logic        o;
        int          cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    int n_cmp  = 0;
    int n_bad  = 0;
    int cyc    = 0;
    int slot_n = 0;

    dual_bin2bcd_converter #(.BIN_W(14)) dut (
        .clk      (clk),
        .rst      (rst),
        .bin_A    (bin_A),
        .bin_B    (bin_B),
        .hold     (hold),
        .digits_A (digits_A),
        .digits_B (digits_B),
        .ovf_A    (ovf_A),
        .ovf_B    (ovf_B),
        .upd_A    (upd_A),
        .upd_B    (upd_B)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decimal reference: saturate at 9999, then split into digits arithmetically.
    function automatic logic [16:0] ref_bcd(input int v);
        logic [15:0] d;
        if (v > 9999) return {1'b1, 16'h9999};
        d[15:12] = 4'((v / 1000) % 10);
        d[11:8]  = 4'((v / 100) % 10);
        d[7:4]   = 4'((v / 10) % 10);
        d[3:0]   = 4'(v % 10);
        return {1'b0, d};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: cycle count since reset release, then compare each publication.
    always @(posedge clk) begin
        exp_t e;
        if (rst) cyc = 0;
        else     cyc = cyc + 1;
        #1;
        if (upd_A) begin
            if (qa.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL upd_A: got unexpected pulse at cycle %0d, required none", cyc);
            end else begin
                e = qa.pop_front();
                chk("digits_A", 32'(digits_A), 32'(e.d));
                chk("ovf_A", 32'(ovf_A), 32'(e.o));
                chk("upd_A_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        if (upd_B) begin
            if (qb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL upd_B: got unexpected pulse at cycle %0d, required none", cyc);
            end else begin
                e = qb.pop_front();
                chk("digits_B", 32'(digits_B), 32'(e.d));
                chk("ovf_B", 32'(ovf_B), 32'(e.o));
                chk("upd_B_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // One 16-cycle conversion slot; called just before that slot's LOAD edge.
    task automatic slot(input int val, input bit hold_v, input int mid_val, input bit use_mid);
        exp_t        e;
        logic [16:0] r;
        bit          is_b;
        is_b = (slot_n % 2) == 1;
        if (is_b) bin_B = 14'(val);
        else      bin_A = 14'(val);
        hold = hold_v;
        if (!hold_v) begin
            r     = ref_bcd(val);
            e.d   = r[15:0];
            e.o   = r[16];
            e.cyc = 16 * (slot_n + 1);
            if (is_b) qb.push_back(e);
            else      qa.push_back(e);
        end
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk);
            if (use_mid && i == 5) begin
                @(negedge clk);
                if (is_b) bin_B = 14'(mid_val);
                else      bin_A = 14'(mid_val);
            end
        end
        @(negedge clk);
        slot_n++;
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_digits_A"}, 32'(digits_A), 32'h0);
        chk({tag, "_digits_B"}, 32'(digits_B), 32'h0);
        chk({tag, "_ovf_A"}, 32'(ovf_A), 32'h0);
        chk({tag, "_ovf_B"}, 32'(ovf_B), 32'h0);
        chk({tag, "_upd_A"}, 32'(upd_A), 32'h0);
        chk({tag, "_upd_B"}, 32'(upd_B), 32'h0);
    endtask

    initial begin
        rst   = 1'b1;
        bin_A = '0;
        bin_B = '0;
        hold  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_cleared("reset");
        rst    = 1'b0;
        slot_n = 0;

        // Basic pair, first publications at cycles 16 and 32
        slot(1234, 1'b0, 0, 1'b0);
        slot(5678, 1'b0, 0, 1'b0);

        // Boundaries on both channels
        slot(0, 1'b0, 0, 1'b0);
        slot(9999, 1'b0, 0, 1'b0);
        slot(9999, 1'b0, 0, 1'b0);
        slot(10000, 1'b0, 0, 1'b0);
        slot(10000, 1'b0, 0, 1'b0);
        slot(16383, 1'b0, 0, 1'b0);
        slot(16383, 1'b0, 0, 1'b0);
        slot(0, 1'b0, 0, 1'b0);

        // Input change during SHIFT is ignored until the next LOAD
        slot(42, 1'b0, 77, 1'b1);
        slot(1, 1'b0, 0, 1'b0);
        slot(77, 1'b0, 0, 1'b0);
        slot(2, 1'b0, 0, 1'b0);

        // Hold suppresses publication of A; release publishes next time
        slot(50, 1'b0, 0, 1'b0);
        slot(3, 1'b0, 0, 1'b0);
        slot(100, 1'b1, 0, 1'b0);
        chk("hold_digits_A", 32'(digits_A), 32'h0050);
        chk("hold_ovf_A", 32'(ovf_A), 32'h0);
        slot(4, 1'b0, 0, 1'b0);
        slot(100, 1'b0, 0, 1'b0);

        // Strided sweep across the whole input range
        for (int v = 0; v < 16384; v += 7) begin
            slot(v, 1'b0, 0, 1'b0);
        end
        slot(16383, 1'b0, 0, 1'b0);
        if ((slot_n % 2) == 0) slot(5, 1'b0, 0, 1'b0);

        // Reset in the middle of a B SHIFT discards the partial result
        bin_B = 14'd999;
        hold  = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_cleared("midrst");
        qa.delete();
        qb.delete();
        slot_n = 0;
        rst    = 1'b0;
        slot(321, 1'b0, 0, 1'b0);
        slot(654, 1'b0, 0, 1'b0);

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("qa_drained", 32'(qa.size()), 32'h0);
        chk("qb_drained", 32'(qb.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
